// File: rtl/fc_layer_seq.sv
// fc_layer_seq -- sequential fully-connected layer.
//
// Computes Y[j] = sat((B[j] << FRAC + sum_i X[i]*W[j][i]) >>> FRAC) for
// j = 0..OUT_N-1, one multiply-accumulate per clock, using a single MAC.
// Each neuron takes IN_N MAC cycles plus one STORE cycle, so a run lasts
// OUT_N*(IN_N+1) busy cycles followed by a one-cycle done pulse.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous active-high reset (aborts any run, clears outputs)
//   start    - begin a layer evaluation (only honoured in IDLE)
//   fcInput  - input vector, X[i] at [i*DATA_WIDTH +: DATA_WIDTH], latched on start
//   weights  - W[j][i] at [(j*IN_N+i)*DATA_WIDTH +: DATA_WIDTH], stable while busy
//   bias     - B[j] at [j*DATA_WIDTH +: DATA_WIDTH]
//   fcOutput - registered results, Y[j] at [j*DATA_WIDTH +: DATA_WIDTH]
//   busy     - high while in MAC or STORE
//   done     - one-cycle pulse when the whole vector has been written
module fc_layer_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC       = 10,
    parameter int IN_N       = 120,
    parameter int OUT_N      = 84
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [IN_N*DATA_WIDTH-1:0]        fcInput,
    input  logic [OUT_N*IN_N*DATA_WIDTH-1:0]  weights,
    input  logic [OUT_N*DATA_WIDTH-1:0]       bias,
    output logic [OUT_N*DATA_WIDTH-1:0]       fcOutput,
    output logic                              busy,
    output logic                              done
);

    // 8 guard bits keep the sum of up to 256 full-scale products exact.
    localparam int ACC_W = 2*DATA_WIDTH + 8;
    localparam int IW    = (IN_N  > 1) ? $clog2(IN_N)  : 1;
    localparam int JW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(IN_N - 1);
    localparam logic [JW-1:0] J_LAST = JW'(OUT_N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [IN_N*DATA_WIDTH-1:0]      r_x;
    logic [IW-1:0]                   r_i;
    logic [JW-1:0]                   r_j;
    logic signed [ACC_W-1:0]         r_acc;
    logic [OUT_N*DATA_WIDTH-1:0]     r_out;
    logic                            r_busy;
    logic                            r_done;

    logic signed [DATA_WIDTH-1:0]    w_x_word;
    logic signed [DATA_WIDTH-1:0]    w_w_word;
    logic signed [2*DATA_WIDTH-1:0]  w_prod;
    logic [JW-1:0]                   w_j_next;
    logic [DATA_WIDTH-1:0]           w_bias_next;

    // Bias word sign-extended to accumulator width and aligned to product scale.
    function automatic logic signed [ACC_W-1:0] bias_to_acc(input logic [DATA_WIDTH-1:0] b);
        logic signed [ACC_W-1:0] ext;
        ext = {{(ACC_W-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
        return ext <<< FRAC;
    endfunction

    // Floor-rescale the accumulator and clamp to the signed output range.
    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        sh = a >>> FRAC;
        hi = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        lo = ~hi;
        if (sh > hi) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (sh < lo) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return sh[DATA_WIDTH-1:0];
        end
    endfunction

    // Operand selection for the current (j, i) and the next neuron's bias.
    always_comb begin
        w_x_word    = r_x[int'(r_i)*DATA_WIDTH +: DATA_WIDTH];
        w_w_word    = weights[(int'(r_j)*IN_N + int'(r_i))*DATA_WIDTH +: DATA_WIDTH];
        w_prod      = w_x_word * w_w_word;
        // Clamp so the bias lookup never indexes past the last neuron.
        if (r_j == J_LAST) begin
            w_j_next = '0;
        end else begin
            w_j_next = r_j + JW'(1);
        end
        w_bias_next = bias[int'(w_j_next)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_MAC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MAC: begin
                if (r_i == I_LAST) begin
                    w_next = S_STORE;
                end else begin
                    w_next = S_MAC;
                end
            end
            S_STORE: begin
                if (r_j == J_LAST) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_MAC;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_MAC) || (w_next == S_STORE);
            r_done <= (w_next == S_DONE);
        end
    end

    // Datapath: input latch, indices, accumulator and result words.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x   <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_acc <= '0;
            r_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x   <= fcInput;
                        r_i   <= '0;
                        r_j   <= '0;
                        r_acc <= bias_to_acc(bias[0 +: DATA_WIDTH]);
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + {{(ACC_W-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
                    if (r_i == I_LAST) begin
                        r_i <= '0;
                    end else begin
                        r_i <= r_i + IW'(1);
                    end
                end
                S_STORE: begin
                    r_out[int'(r_j)*DATA_WIDTH +: DATA_WIDTH] <= saturate(r_acc);
                    if (r_j != J_LAST) begin
                        r_j   <= w_j_next;
                        r_i   <= '0;
                        r_acc <= bias_to_acc(w_bias_next);
                    end
                end
                S_DONE: begin
                    r_i <= '0;
                end
                default: begin
                    r_i <= '0;
                end
            endcase
        end
    end

    assign fcOutput = r_out;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: doc/fc_layer_seq.md
FC_LAYER_SEQ -- requirements
Module: fc_layer_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of every input, weight, bias and output word (signed fixed point, two's complement).
REQ-002 Parameter FRAC, default 10: fractional bits of every word (Q5.10 at defaults).
REQ-003 Parameter IN_N, default 120: input vector length (the 120 conv-stage outputs).
REQ-004 Parameter OUT_N, default 84: number of neurons computed.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to run one full layer evaluation; sampled only in IDLE.
REQ-008 fcInput  input  IN_N*DATA_WIDTH  input vector; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 weights  input  OUT_N*IN_N*DATA_WIDTH  weight W[j][i] at bits [(j*IN_N+i)*DATA_WIDTH +: DATA_WIDTH]; must stay stable while busy=1.
REQ-010 bias  input  OUT_N*DATA_WIDTH  bias B[j] at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-011 fcOutput  output  OUT_N*DATA_WIDTH  registered result Y[j] at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-012 busy  output  1  high in MAC and STORE states.
REQ-013 done  output  1  one-cycle pulse, high only in DONE state.

Function
REQ-014 FSM states IDLE, MAC, STORE, DONE; reset state IDLE.
REQ-015 IDLE: on edge with start=1, latch fcInput into internal register, set neuron index j=0, input index i=0, load accumulator with B[0] sign-extended and shifted left FRAC, go to MAC.
REQ-016 MAC: each edge adds sign-extended product X[i]*W[j][i] (2*DATA_WIDTH bits) to accumulator, increments i; after the edge with i=IN_N-1 go to STORE.
REQ-017 Accumulator width 2*DATA_WIDTH+8 bits signed; no intermediate overflow for IN_N <= 256.
REQ-018 STORE: one edge writes Y[j] = saturate(acc >>> FRAC); arithmetic shift (floor rounding), clamp to [0x7FFF max, 0x8000 min] at DATA_WIDTH=16.
REQ-019 STORE: if j<OUT_N-1, increment j, reset i=0, reload accumulator with B[j+1]<<FRAC, go to MAC; else go to DONE.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE on next edge regardless of start.
REQ-021 Latency: start sampled at edge k -> done high in cycle after edge k+OUT_N*(IN_N+1); no bubbles.
REQ-022 start ignored in MAC, STORE, DONE; no queuing.
REQ-023 fcInput changes after the start edge do not affect the result (latched copy used).
REQ-024 fcOutput words hold last written value; words not yet rewritten in the current run keep previous run's values; full vector valid from done cycle until next run's first STORE.
REQ-025 Back-to-back: start high in the IDLE cycle immediately after DONE begins a new run.

Reset
REQ-026 reset=1 at any edge, including mid-run: state IDLE, busy=0, done=0, fcOutput all zero, j=i=0, accumulator zero; no done pulse for the aborted run.
REQ-027 reset has priority over start on the same edge.

Verification (bench parameters IN_N=4, OUT_N=2, DATA_WIDTH=16, FRAC=10; latency 10 edges)
REQ-028 All X=0x0400, all W=0x0400, B=0 -> Y[0]=Y[1]=0x1000; busy high 10 cycles; done single pulse in cycle after edge k+10.
REQ-029 All X=0x7FFF, W=0x7FFF -> Y=0x7FFF; W=0x8000 -> Y=0x8000 (saturation both signs).
REQ-030 W=0, B[0]=0xFC00, B[1]=0x0200 -> Y[0]=0xFC00, Y[1]=0x0200.
REQ-031 X[0]=0x0001, W[0][0]=0xFFFF, rest 0, B=0 -> Y[0]=0xFFFF (floor of -2^-20), Y[1]=0x0000.
REQ-032 Change fcInput and pulse start at edge k+3 -> results identical to REQ-028, still one done pulse at k+10.
REQ-033 Assert reset at edge k+5 -> busy=0, done=0, fcOutput=0 next cycle; no done pulse; new start then completes normally.
